// File: rtl/mult_operand_issuer_pkg.sv
// Shared widths and FSM encoding for the shift-add multiplier front end.
package mult_operand_issuer_pkg;

    localparam int MULT_W  = 16;
    localparam int MCAND_W = 4;
    localparam int PROD_W  = MULT_W + MCAND_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_operand_issuer_if.sv
// Operand intake, result delivery and multiplier link of the operand issuer.
interface mult_operand_issuer_if;
    import mult_operand_issuer_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [MULT_W-1:0]   in_mult;
    logic [MCAND_W-1:0]  in_mcand;
    logic                out_valid;
    logic                out_ready;
    logic [PROD_W-1:0]   out_product;
    logic                out_err;
    logic [MULT_W-1:0]   mul_mult;
    logic [MCAND_W-1:0]  mul_mcand;
    logic                mul_st;
    logic [PROD_W-1:0]   mul_product;
    logic                mul_done;

    // The issuer itself is the slave; producer, consumer and multiplier form the master side.
    modport slave (
        input  in_valid, in_mult, in_mcand, out_ready, mul_product, mul_done,
        output in_ready, out_valid, out_product, out_err, mul_mult, mul_mcand, mul_st
    );

    modport master (
        output in_valid, in_mult, in_mcand, out_ready, mul_product, mul_done,
        input  in_ready, out_valid, out_product, out_err, mul_mult, mul_mcand, mul_st
    );

endinterface

// File: rtl/mult_operand_issuer_sync_fifo.sv
// Single-clock FIFO for operand pairs; full/empty derive from a registered occupancy count.
module mult_operand_issuer_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; validity is defined purely by pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_operand_issuer.sv
// Buffers operand pairs, issues each to the multiplier with a St pulse, and returns the
// product (or a timeout error) to the downstream consumer.
module mult_operand_issuer
    import mult_operand_issuer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    mult_operand_issuer_if.slave bus
);

    localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    state_t             state;
    logic [TW-1:0]      timer;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [PROD_W-1:0]  fifo_head;

    assign pop          = (state == IDLE) && !fifo_empty;
    assign bus.in_ready = !fifo_full;

    mult_operand_issuer_sync_fifo #(
        .WIDTH (MULT_W + MCAND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata ({bus.in_mult, bus.in_mcand}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            bus.mul_mult    <= '0;
            bus.mul_mcand   <= '0;
            bus.mul_st      <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_product <= '0;
            bus.out_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        bus.mul_mult  <= fifo_head[PROD_W-1:MCAND_W];
                        bus.mul_mcand <= fifo_head[MCAND_W-1:0];
                        bus.mul_st    <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    // Done is deliberately not looked at here: a trailing Done from the previous job must not complete this one.
                    bus.mul_st <= 1'b0;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        bus.out_product <= bus.mul_product;
                        bus.out_err     <= 1'b0;
                        bus.out_valid   <= 1'b1;
                        state           <= HOLD;
                    end else if (timer == TIMER_LAST) begin
                        bus.out_product <= '0;
                        bus.out_err     <= 1'b1;
                        bus.out_valid   <= 1'b1;
                        state           <= HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_operand_issuer.sv
// Directed bench for mult_operand_issuer with a behavioural shift-add multiplier model.
`timescale 1ns/1ps
module tb_mult_operand_issuer;
    import mult_operand_issuer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int st_count   = 0;
    int st_cycle   = 0;
    int res_count  = 0;
    int res_cycle  = 0;
    logic prev_st  = 1'b0;

    // Multiplier model: Done rises model_lat+1 cycles after the St cycle, for model_done_len cycles.
    int  model_lat      = 3;
    int  model_done_len = 1;
    bit  model_done     = 1'b1;
    int  delay          = 0;
    int  done_left      = 0;
    logic [PROD_W-1:0] model_prod = '0;

    mult_operand_issuer_if bus();

    mult_operand_issuer #(.DEPTH(4), .TIMEOUT(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (done_left != 0) done_left <= done_left - 1;
        if (bus.mul_st) begin
            delay      <= model_lat;
            model_prod <= PROD_W'(bus.mul_mult) * PROD_W'(bus.mul_mcand);
        end else if (delay != 0) begin
            delay <= delay - 1;
            if (delay == 1 && model_done) done_left <= model_done_len;
        end
    end

    assign bus.mul_done    = (done_left != 0);
    assign bus.mul_product = model_prod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mul_st) begin
            check("st_one_cycle", 32'(prev_st), 0);
            st_count++;
            st_cycle = cyc;
        end
        prev_st = bus.mul_st;
        if (bus.out_valid && bus.out_ready) res_count++;
    end

    task automatic push(input logic [MULT_W-1:0] m, input logic [MCAND_W-1:0] c);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_mult  = m;
        bus.in_mcand = c;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [PROD_W-1:0] ep, input logic ee);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        res_cycle = cyc;
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_prod"},  32'(bus.out_product), 32'(ep));
        check({tag, "_err"},   32'(bus.out_err), 32'(ee));
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_prod"},  32'(bus.out_product), 0);
        check({tag, "_out_err"},   32'(bus.out_err), 0);
        check({tag, "_mul_mult"},  32'(bus.mul_mult), 0);
        check({tag, "_mul_mcand"}, 32'(bus.mul_mcand), 0);
        check({tag, "_mul_st"},    32'(bus.mul_st), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_st;
        int snap_res;
        int r2c;
        int bad;
        int n;
        logic any_valid;

        bus.in_valid  = 1'b0;
        bus.in_mult   = '0;
        bus.in_mcand  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        #30 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single job: pulse timing and operand presentation
        push(16'd9, 4'd5);
        @(negedge clk); check("t1_st_pre", 32'(bus.mul_st), 0);
        @(negedge clk);
        check("t1_st", 32'(bus.mul_st), 1);
        check("t1_mult", 32'(bus.mul_mult), 9);
        check("t1_mcand", 32'(bus.mul_mcand), 5);
        @(negedge clk);
        check("t1_st_post", 32'(bus.mul_st), 0);
        check("t1_mult_wait", 32'(bus.mul_mult), 9);
        wait_result("t1", 20'd45, 1'b0);

        // Backpressure: result held, FIFO fills behind it
        bus.out_ready = 1'b0;
        push(16'd9, 4'd5);
        wait_result("t3_first", 20'd45, 1'b0);
        snap_st = st_count;
        push(16'd11, 4'd15);
        push(16'd0, 4'd8);
        push(16'd65535, 4'd15);
        push(16'd7, 4'd3);
        check("t2_full", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_mult  = 16'd1;
        bus.in_mcand = 4'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bad = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.out_product !== 20'd45 || bus.out_valid !== 1'b1) bad++;
        end
        check("t3_hold_stable", bad, 0);
        check("t3_hold_err", 32'(bus.out_err), 0);
        check("t3_no_st", st_count, snap_st);

        bus.out_ready = 1'b1;
        wait_result("t3_release", 20'd45, 1'b0);
        wait_result("t2_r2", 20'd165, 1'b0);
        r2c = res_cycle;
        wait_result("t2_r3", 20'd0, 1'b0);
        check("t2_period", res_cycle - r2c, 7);
        wait_result("t2_r4", 20'd983025, 1'b0);
        wait_result("t2_r5", 20'd21, 1'b0);
        snap_res = res_count;
        repeat (20) @(negedge clk);
        check("t2_no_extra", res_count, snap_res);
        check("t2_ready_again", 32'(bus.in_ready), 1);

        // Timeout: multiplier never answers
        model_done = 1'b0;
        push(16'd3, 4'd3);
        wait_result("t4_timeout", 20'd0, 1'b1);
        check("t4_timeout_cycles", res_cycle - st_cycle, 33);
        model_done = 1'b1;
        push(16'd6, 4'd7);
        wait_result("t4_next", 20'd42, 1'b0);

        // Reset while waiting on the multiplier
        model_lat = 5;
        snap_res  = res_count;
        push(16'd5, 4'd5);
        n = 0;
        while (!bus.mul_st && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_st_seen", 32'(bus.mul_st), 1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        #19 rst_n = 1'b1;
        any_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            any_valid |= bus.out_valid;
        end
        check("t5_no_result", 32'(any_valid), 0);
        check("t5_res_count", res_count, snap_res);
        model_lat = 3;
        @(posedge clk); #1;
        push(16'd8, 4'd2);
        wait_result("t5_recover", 20'd16, 1'b0);

        // Multi-cycle Done: one result per job
        model_done_len = 3;
        snap_res = res_count;
        snap_st  = st_count;
        push(16'd2, 4'd3);
        push(16'd4, 4'd5);
        wait_result("t6_a", 20'd6, 1'b0);
        wait_result("t6_b", 20'd20, 1'b0);
        repeat (20) @(negedge clk);
        check("t6_results", res_count, snap_res + 2);
        check("t6_starts", st_count, snap_st + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
